jt12_single_accum: RTL and testbench

- Signed running accumulator for one audio output channel (left or right) of the FM mixer.
- Sums gated operator/sample contributions over one sample period.
- On the period-start strobe `zero`, publishes the completed sum to `snd` and restarts accumulation.
- One instance per stereo side, fed by the mixer's per-slot input selection logic.

---
 rtl/jt12_single_accum_if.sv | 13 +
 rtl/jt12_single_accum.sv | 33 +++
 tb/tb_jt12_single_accum.sv | 125 ++++++++++++
 3 files changed

// File: rtl/jt12_single_accum_if.sv
// jt12_single_accum_if: data bus between the mixer slot logic and one accumulator channel.
interface jt12_single_accum_if #(
    parameter int win  = 14,
    parameter int wout = 16
);
    logic                   clk_en;
    logic signed [win-1:0]  op_result;
    logic                   sum_en;
    logic                   zero;
    logic signed [wout-1:0] snd;
    modport master (output clk_en, op_result, sum_en, zero, input snd);
    modport slave  (input clk_en, op_result, sum_en, zero, output snd);
endinterface

// File: rtl/jt12_single_accum.sv
// jt12_single_accum: per-channel signed running sum, published to snd on each zero strobe.
// Define JT12_ACC_SATURATE_EN to clamp overflowing sums instead of wrapping.
module jt12_single_accum #(
    parameter int win  = 14,
    parameter int wout = 16
) (
    input logic                clk,
    input logic                rst_n,
    jt12_single_accum_if.slave bus
);
    logic signed [wout-1:0] cur, nxt, acc, acc_d;
    always_comb begin
        cur = bus.sum_en ? wout'(bus.op_result) : '0;
        nxt = bus.zero ? cur : acc + cur;
`ifdef JT12_ACC_SATURATE_EN
        // overflow only when operands share a sign and the result flips it
        acc_d = (!bus.zero && acc[wout-1] == cur[wout-1] && nxt[wout-1] != acc[wout-1])
              ? (acc[wout-1] ? {1'b1, {(wout-1){1'b0}}} : {1'b0, {(wout-1){1'b1}}})
              : nxt;
`else
        acc_d = nxt;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            bus.snd <= '0;
        end else if (bus.clk_en) begin
            acc <= acc_d;
            if (bus.zero) bus.snd <= acc;
        end
    end
endmodule

// File: tb/tb_jt12_single_accum.sv
// tb_jt12_single_accum: directed vectors against an integer model of the accumulator.
module tb_jt12_single_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int compared = 0;
    int mismatched = 0;
    int m_acc = 0;
    int m_snd = 0;
    bit checking = 1'b0;

    jt12_single_accum_if #(.win(14), .wout(16)) bus ();
    jt12_single_accum #(.win(14), .wout(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int fit(input int s);
`ifdef JT12_ACC_SATURATE_EN
        return s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
`else
        return ((s + 32768 + 65536) % 65536) - 32768;
`endif
    endfunction

    task automatic step(input bit rn, input bit en, input bit z, input bit se, input int op);
        int cur;
        rst_n         = rn;
        bus.clk_en    = en;
        bus.zero      = z;
        bus.sum_en    = se;
        bus.op_result = 14'(op);
        @(posedge clk);
        #1;
        cur = se ? op : 0;
        if (!rn) begin
            m_acc = 0;
            m_snd = 0;
        end else if (en) begin
            if (z) begin
                m_snd = m_acc;
                m_acc = cur;
            end else m_acc = fit(m_acc + cur);
        end
        checking = 1'b1;
    endtask

    task automatic chk(input string name, input int exp);
        compared++;
        if (int'(bus.snd) != exp) begin
            mismatched++;
            $display("FAIL %s: snd=%0d expected=%0d", name, int'(bus.snd), exp);
        end
    endtask

    always @(negedge clk) if (checking) begin
        compared++;
        if (int'(bus.snd) != m_snd) begin
            mismatched++;
            $display("FAIL model t=%0t: snd=%0d expected=%0d", $time, int'(bus.snd), m_snd);
        end
    end

    initial begin
        bus.clk_en = 1'b1; bus.zero = 1'b0; bus.sum_en = 1'b0; bus.op_result = '0;
        // reset with busy inputs
        step(0, 1, 1, 1, 1234);
        step(0, 1, 0, 1, -77);
        chk("reset", 0);
        step(1, 1, 1, 0, 555);
        chk("post_reset_zero", 0);
        // basic sum
        step(1, 1, 1, 1, 100);
        step(1, 1, 0, 1, 200);
        step(1, 1, 0, 1, -50);
        step(1, 1, 0, 0, 8191);
        step(1, 1, 1, 1, 0);
        chk("basic_sum", 250);
        // clk_en gating
        step(1, 1, 0, 1, 10);
        step(1, 0, 1, 1, 999);
        step(1, 0, 0, 1, -999);
        step(1, 1, 0, 1, 20);
        step(1, 0, 1, 1, 4000);
        chk("gated_hold", 250);
        step(1, 1, 1, 1, 0);
        chk("gated_sum", 30);
        // positive overflow
        for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 8191);
        step(1, 1, 0, 1, -1);
        step(1, 1, 1, 1, 0);
`ifdef JT12_ACC_SATURATE_EN
        chk("pos_sat", 32766);
`else
        chk("pos_wrap", -16391);
`endif
        // negative overflow
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, -8192);
        step(1, 1, 1, 1, 0);
`ifdef JT12_ACC_SATURATE_EN
        chk("neg_sat", -32768);
`else
        chk("neg_wrap", 24576);
`endif
        // back-to-back zero
        step(1, 1, 1, 1, 5);
        chk("b2b_first", 0);
        step(1, 1, 1, 1, 6);
        chk("b2b_second", 5);
        step(1, 1, 1, 1, 7);
        chk("b2b_third", 6);
        // reset mid-period discards partial sum
        step(1, 1, 0, 1, 123);
        step(0, 0, 0, 1, 50);
        chk("mid_reset", 0);
        step(1, 1, 1, 1, 1);
        chk("after_mid_reset", 0);
        step(1, 1, 1, 0, 0);
        chk("single_slot", 1);
        step(1, 1, 0, 1, -8192);
        step(1, 1, 1, 1, 0);
        chk("min_input", -8192);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
